mem_write_checker: RTL and testbench

Parametrised, synthesisable checker that watches the processor's data-memory write port (memwrite, dataadr, writedata) and compares it against a programmable table of expected writes. It replaces the fixed "address 84 / data 7" pass test and the fixed stop-after-200 timer with a table-driven in-order check, an ignore address, strict or lenient matching, and a cycle watchdog. It sits beside the `top` instance in the processor bench or an FPGA harness, and reports pass, fail or timeout status with error capture.

---
 rtl/mem_write_checker_if.sv | 13 +
 rtl/mem_write_checker.sv | 125 ++++++++++++
 tb/tb_mem_write_checker.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_write_checker_if.sv
// Processor data-memory write port as seen by the write checker.
// The processor (or bench) drives it as master; the checker only observes it.
interface mem_write_checker_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              memwrite;
  logic [ADDR_W-1:0] dataadr;
  logic [DATA_W-1:0] writedata;

  modport master (output memwrite, dataadr, writedata);
  modport slave  (input  memwrite, dataadr, writedata);
endinterface

// File: rtl/mem_write_checker.sv
// Table-driven in-order checker for data-memory writes.
// Reports pass/fail/timeout, with capture of the offending write.
module mem_write_checker #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH       = 8,
  parameter int                TIMEOUT     = 200,
  parameter int                CNT_W       = 16,
  parameter bit                STRICT      = 1'b1,
  parameter bit                IGNORE_EN   = 1'b1,
  parameter logic [ADDR_W-1:0] IGNORE_ADDR = ADDR_W'(80),
  localparam int               IDX_W       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [IDX_W:0]    cfg_len,
  mem_write_checker_if.slave mw,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [IDX_W:0]    match_cnt,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_data,
  output logic [CNT_W-1:0]  cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_PASS = 3'd2,
    S_FAIL = 3'd3,
    S_TOUT = 3'd4
  } state_t;

  state_t            state;
  state_t            nxt;
  logic [ADDR_W-1:0] tbl_addr [DEPTH];
  logic [DATA_W-1:0] tbl_data [DEPTH];
  logic [IDX_W:0]    len;

  logic [IDX_W-1:0]  ptr;
  logic              chk;
  logic              addr_hit;
  logic              hit;
  logic              miss;
  logic              last;
  logic              wdog;
  logic              go;

  always_comb begin
    ptr      = match_cnt[IDX_W-1:0];
    chk      = mw.memwrite && !(IGNORE_EN && (mw.dataadr == IGNORE_ADDR));
    addr_hit = (mw.dataadr == tbl_addr[ptr]);
    hit      = chk && addr_hit && (mw.writedata == tbl_data[ptr]);
    // Lenient mode only objects to wrong data at the expected address.
    miss     = chk && !hit && (STRICT || addr_hit);
    last     = hit && ((match_cnt + (IDX_W+1)'(1)) == len);
    wdog     = (cycle_cnt == CNT_W'(TIMEOUT - 1));
    go       = start && (state != S_RUN);

    nxt = state;
    if (go) begin
      nxt = (cfg_len == '0) ? S_PASS : S_RUN;
    end else if (state == S_RUN) begin
      if (miss)      nxt = S_FAIL;
      else if (last) nxt = S_PASS;
      else if (wdog) nxt = S_TOUT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
      len       <= '0;
      match_cnt <= '0;
      err_addr  <= '0;
      err_data  <= '0;
      cycle_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_addr[i] <= '0;
        tbl_data[i] <= '0;
      end
    end else begin
      state   <= nxt;
      busy    <= (nxt == S_RUN);
      done    <= (nxt == S_PASS) || (nxt == S_FAIL) || (nxt == S_TOUT);
      pass    <= (nxt == S_PASS);
      fail    <= (nxt == S_FAIL);
      timeout <= (nxt == S_TOUT);

      if ((state == S_IDLE) && cfg_we) begin
        tbl_addr[cfg_idx] <= cfg_addr;
        tbl_data[cfg_idx] <= cfg_data;
      end

      if (go) begin
        len       <= cfg_len;
        match_cnt <= '0;
        cycle_cnt <= '0;
        err_addr  <= '0;
        err_data  <= '0;
      end else if (state == S_RUN) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
        if (hit) match_cnt <= match_cnt + (IDX_W+1)'(1);
        if (miss) begin
          err_addr <= mw.dataadr;
          err_data <= mw.writedata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: a strict and a lenient instance share one write port.
module tb_mem_write_checker;
  localparam int TO = 200;

  typedef struct packed {
    logic        busy, done, pass, fail, tout;
    logic [3:0]  mcnt;
    logic [31:0] ea, ed;
    logic [15:0] cc;
  } st_t;

  logic clk = 1'b0;
  logic reset, start_s, start_l, cfg_we;
  logic [2:0]  cfg_idx;
  logic [31:0] cfg_addr, cfg_data;
  logic [3:0]  cfg_len;

  logic s_busy, s_done, s_pass, s_fail, s_tout;
  logic l_busy, l_done, l_pass, l_fail, l_tout;
  logic [3:0]  s_mcnt, l_mcnt;
  logic [31:0] s_ea, s_ed, l_ea, l_ed;
  logic [15:0] s_cc, l_cc;

  int nchk = 0;
  int nfail = 0;
  st_t sb[$];
  st_t e, o;
  bit ok;

  mem_write_checker_if #(.ADDR_W(32), .DATA_W(32)) mw_if ();

  mem_write_checker #(.TIMEOUT(TO), .STRICT(1'b1)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_len(cfg_len), .mw(mw_if),
    .busy(s_busy), .done(s_done), .pass(s_pass), .fail(s_fail), .timeout(s_tout),
    .match_cnt(s_mcnt), .err_addr(s_ea), .err_data(s_ed), .cycle_cnt(s_cc));

  mem_write_checker #(.TIMEOUT(TO), .STRICT(1'b0)) dut_l (
    .clk(clk), .reset(reset), .start(start_l), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_len(cfg_len), .mw(mw_if),
    .busy(l_busy), .done(l_done), .pass(l_pass), .fail(l_fail), .timeout(l_tout),
    .match_cnt(l_mcnt), .err_addr(l_ea), .err_data(l_ed), .cycle_cnt(l_cc));

  always #5 clk = ~clk;

  function automatic st_t mk(input logic b, d, p, f, t, input int m, ea, ed, cc);
    mk = '{busy:b, done:d, pass:p, fail:f, tout:t, mcnt:4'(m), ea:ea, ed:ed, cc:16'(cc)};
  endfunction

  function automatic st_t obs_s();
    obs_s = '{busy:s_busy, done:s_done, pass:s_pass, fail:s_fail, tout:s_tout,
              mcnt:s_mcnt, ea:s_ea, ed:s_ed, cc:s_cc};
  endfunction

  function automatic st_t obs_l();
    obs_l = '{busy:l_busy, done:l_done, pass:l_pass, fail:l_fail, tout:l_tout,
              mcnt:l_mcnt, ea:l_ea, ed:l_ed, cc:l_cc};
  endfunction

  // Status bits must agree with each other on every cycle.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      nchk++;
      if ((s_done !== (s_pass | s_fail | s_tout)) || (s_busy & s_done) ||
          ((32'(s_pass) + 32'(s_fail) + 32'(s_tout)) > 1) ||
          (l_done !== (l_pass | l_fail | l_tout)) || (l_busy & l_done) ||
          ((32'(l_pass) + 32'(l_fail) + 32'(l_tout)) > 1)) begin
        nfail++;
        $display("FAIL consistency: strict=%b%b%b%b%b lenient=%b%b%b%b%b required one-hot consistent",
                 s_busy, s_done, s_pass, s_fail, s_tout, l_busy, l_done, l_pass, l_fail, l_tout);
      end
    end
  end

  // All stimulus tasks start and end on a falling edge.
  task automatic do_write(input int a, input int d);
    mw_if.memwrite = 1'b1; mw_if.dataadr = a; mw_if.writedata = d;
    @(negedge clk);
    mw_if.memwrite = 1'b0;
  endtask

  task automatic do_start(input bit l, input int len);
    cfg_len = 4'(len);
    if (l) start_l = 1'b1; else start_s = 1'b1;
    @(negedge clk);
    start_l = 1'b0; start_s = 1'b0;
  endtask

  task automatic cfg_entry(input int i, input int a, input int d);
    cfg_we = 1'b1; cfg_idx = 3'(i); cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_done(input bit l, input int bound, output bit got);
    for (int i = 0; i < bound && !(l ? l_done : s_done); i++) @(negedge clk);
    got = l ? l_done : s_done;
    if (!got) begin
      nchk++; nfail++;
      $display("FAIL wait_done: done=0 after %0d cycles, required 1", bound);
    end
  endtask

  task automatic test_reset;
    nchk++;
    if (obs_s() !== '0 || obs_l() !== '0) begin
      nfail++; $display("FAIL reset_hold: strict=%h lenient=%h required 0", obs_s(), obs_l());
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    nchk++;
    if (obs_s() !== '0 || obs_l() !== '0) begin
      nfail++; $display("FAIL reset_idle: strict=%h lenient=%h required 0", obs_s(), obs_l());
    end
  endtask

  task automatic test_legacy_pass;
    cfg_entry(0, 84, 7);
    cfg_entry(1, 88, 9);
    sb.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0, 2));
    do_start(0, 1);
    nchk++;
    if (s_busy !== 1'b1) begin nfail++; $display("FAIL start_busy: busy=%b required 1", s_busy); end
    do_write(80, 5);
    nchk++;
    if (s_busy !== 1'b1 || s_mcnt !== 4'd0) begin
      nfail++; $display("FAIL ignore_skip: busy=%b match_cnt=%0d required 1/0", s_busy, s_mcnt);
    end
    do_write(84, 7);
    nchk++;
    if (s_pass !== 1'b1) begin nfail++; $display("FAIL pass_latency: pass=%b required 1", s_pass); end
    wait_done(0, 5, ok);
    e = sb.pop_front(); o = obs_s(); nchk++;
    if (o !== e) begin nfail++; $display("FAIL legacy_pass: got %h required %h", o, e); end
  endtask

  task automatic test_restart;
    sb.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0, 1));
    do_start(0, 1);
    do_write(84, 7);
    wait_done(0, 5, ok);
    e = sb.pop_front(); o = obs_s(); nchk++;
    if (o !== e) begin nfail++; $display("FAIL restart_pass: got %h required %h", o, e); end
  endtask

  task automatic test_legacy_fail;
    sb.push_back(mk(0, 1, 0, 1, 0, 0, 88, 7, 1));
    do_start(0, 1);
    do_write(88, 7);
    wait_done(0, 5, ok);
    e = sb.pop_front(); o = obs_s(); nchk++;
    if (o !== e) begin nfail++; $display("FAIL legacy_fail: got %h required %h", o, e); end
  endtask

  task automatic test_control;
    sb.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0));
    do_start(0, 0);
    e = sb.pop_front(); o = obs_s(); nchk++;
    if (o !== e) begin nfail++; $display("FAIL len0_pass: got %h required %h", o, e); end

    sb.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0, 3));
    do_start(0, 1);
    do_start(0, 0);
    nchk++;
    if (s_busy !== 1'b1 || s_done !== 1'b0) begin
      nfail++; $display("FAIL start_in_run: busy=%b done=%b required 1/0", s_busy, s_done);
    end
    cfg_entry(0, 84, 99);
    do_write(84, 7);
    wait_done(0, 5, ok);
    e = sb.pop_front(); o = obs_s(); nchk++;
    if (o !== e) begin nfail++; $display("FAIL cfg_in_run: got %h required %h", o, e); end
  endtask

  task automatic test_watchdog;
    sb.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, TO));
    do_start(0, 2);
    do_write(84, 7);
    repeat (TO - 2) @(negedge clk);
    nchk++;
    if (s_busy !== 1'b1 || s_tout !== 1'b0) begin
      nfail++; $display("FAIL wdog_early: busy=%b timeout=%b cycle_cnt=%0d required 1/0", s_busy, s_tout, s_cc);
    end
    @(negedge clk);
    e = sb.pop_front(); o = obs_s(); nchk++;
    if (o !== e) begin nfail++; $display("FAIL wdog_exact: got %h required %h", o, e); end

    sb.push_back(mk(0, 1, 1, 0, 0, 2, 0, 0, TO));
    do_start(0, 2);
    do_write(84, 7);
    repeat (TO - 2) @(negedge clk);
    do_write(88, 9);
    e = sb.pop_front(); o = obs_s(); nchk++;
    if (o !== e) begin nfail++; $display("FAIL wdog_vs_pass: got %h required %h", o, e); end
  endtask

  task automatic test_reset_mid_run;
    do_start(0, 1);
    do_write(80, 1);
    #2 reset = 1'b0;
    #1;
    nchk++;
    if (obs_s() !== '0) begin nfail++; $display("FAIL async_reset: got %h required 0", obs_s()); end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    do_write(84, 7);
    nchk++;
    if (obs_s() !== '0) begin nfail++; $display("FAIL quiet_after_reset: got %h required 0", obs_s()); end

    sb.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0));
    do_start(0, 0);
    e = sb.pop_front(); o = obs_s(); nchk++;
    if (o !== e) begin nfail++; $display("FAIL len0_after_reset: got %h required %h", o, e); end

    sb.push_back(mk(0, 1, 0, 1, 0, 0, 84, 7, 1));
    do_start(0, 1);
    do_write(84, 7);
    wait_done(0, 5, ok);
    e = sb.pop_front(); o = obs_s(); nchk++;
    if (o !== e) begin nfail++; $display("FAIL table_cleared: got %h required %h", o, e); end
  endtask

  task automatic test_lenient;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    cfg_entry(0, 4, 1);
    cfg_entry(1, 8, 2);
    cfg_entry(2, 12, 3);
    sb.push_back(mk(0, 1, 1, 0, 0, 3, 0, 0, 5));
    do_start(1, 3);
    do_write(100, 9);
    do_write(4, 1);
    do_write(8, 2);
    do_write(20, 0);
    nchk++;
    if (l_busy !== 1'b1 || l_mcnt !== 4'd2) begin
      nfail++; $display("FAIL lenient_skip: busy=%b match_cnt=%0d required 1/2", l_busy, l_mcnt);
    end
    do_write(12, 3);
    wait_done(1, 5, ok);
    e = sb.pop_front(); o = obs_l(); nchk++;
    if (o !== e) begin nfail++; $display("FAIL lenient_pass: got %h required %h", o, e); end

    sb.push_back(mk(0, 1, 0, 1, 0, 1, 8, 5, 2));
    do_start(1, 3);
    do_write(4, 1);
    do_write(8, 5);
    wait_done(1, 5, ok);
    e = sb.pop_front(); o = obs_l(); nchk++;
    if (o !== e) begin nfail++; $display("FAIL lenient_fail: got %h required %h", o, e); end
  endtask

  initial begin
    reset = 1'b0; start_s = 1'b0; start_l = 1'b0; cfg_we = 1'b0;
    cfg_idx = '0; cfg_addr = '0; cfg_data = '0; cfg_len = '0;
    mw_if.memwrite = 1'b0; mw_if.dataadr = '0; mw_if.writedata = '0;
    repeat (3) @(negedge clk);
    test_reset;
    test_legacy_pass;
    test_restart;
    test_legacy_fail;
    test_control;
    test_watchdog;
    test_reset_mid_run;
    test_lenient;
    nchk++;
    if (sb.size() != 0) begin nfail++; $display("FAIL scoreboard_drain: %0d left, required 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
